// File: rtl/scan_config_ctrl_if.sv
// ---------------------------------------------------------------------------
// scan_config_ctrl_if
// Host-side bundle of the configuration loader: load control, the config
// word valid/ready handshake and the readback word stream.
//   start, chain_sel       host -> ctrl  begin a load on CLB (0) or conn (1)
//   busy, done             ctrl -> host  load in progress / load complete pulse
//   data_in, data_valid    host -> ctrl  config word, bit 0 shifted first
//   data_ready             ctrl -> host  controller accepts a word
//   rd_data, rd_valid      ctrl -> host  displaced configuration, no backpressure
// Modports: master = host, slave = controller.
// ---------------------------------------------------------------------------
interface scan_config_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  chain_sel;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output start, chain_sel, data_in, data_valid,
    input  busy, done, data_ready, rd_data, rd_valid
  );

  modport slave (
    input  start, chain_sel, data_in, data_valid,
    output busy, done, data_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/scan_config_ctrl.sv
// ---------------------------------------------------------------------------
// scan_config_ctrl
// Configuration loader for the tiled FPGA array. Host words arrive on the
// bus interface and are serialised LSB first into either the CLB or the
// connection scan chain. The bits falling out of the chain while shifting
// are reassembled into readback words (first captured bit in bit 0).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   bus (slave)                start/chain_sel/busy/done, data_* handshake,
//                              rd_data/rd_valid readback
//   clb_scan_in/en/out         CLB chain serial in, shift enable, serial out
//   conn_scan_in/en/out        connection chain serial in, enable, serial out
// ---------------------------------------------------------------------------
module scan_config_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int CLB_CHAIN_LEN  = 64,
  parameter int CONN_CHAIN_LEN = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                clk,
  input  logic                rst,
  scan_config_ctrl_if.slave   bus,
  output logic                clb_scan_in,
  output logic                clb_scan_en,
  input  logic                clb_scan_out,
  output logic                conn_scan_in,
  output logic                conn_scan_en,
  input  logic                conn_scan_out
);

  localparam int WB_W  = $clog2(DATA_WIDTH + 1);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_WORD = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;
  localparam logic [1:0] ST_FINISH    = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CLB_LEN  = CNT_WIDTH'(CLB_CHAIN_LEN);
  localparam logic [CNT_WIDTH-1:0] CONN_LEN = CNT_WIDTH'(CONN_CHAIN_LEN);
  localparam logic [WB_W-1:0]      WB_LAST  = WB_W'(DATA_WIDTH - 1);

  logic [1:0]            state;
  logic                  sel_q;
  logic [DATA_WIDTH-1:0] sreg;
  logic [WB_W-1:0]       word_bit;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0] rd_sreg;
  logic [WB_W-1:0]       rd_bit;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  logic [CNT_WIDTH-1:0]  chain_len;
  logic                  last_bit;
  logic                  last_of_word;
  logic                  scan_out_sel;
  logic                  shifting;

  assign chain_len    = sel_q ? CONN_LEN : CLB_LEN;
  assign last_bit     = (bit_cnt == chain_len - CNT_WIDTH'(1));
  assign last_of_word = (word_bit == WB_LAST);
  assign scan_out_sel = sel_q ? conn_scan_out : clb_scan_out;
  assign shifting     = (state == ST_SHIFT);

  // Only the latched chain ever sees scan_en, so both enables can never be
  // high together; scan_in is gated so the idle chain sees a constant 0.
  assign clb_scan_en  = shifting & ~sel_q;
  assign conn_scan_en = shifting &  sel_q;
  assign clb_scan_in  = clb_scan_en  & sreg[0];
  assign conn_scan_in = conn_scan_en & sreg[0];

  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_FINISH);
  assign bus.data_ready = (state == ST_WAIT_WORD);
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;

  // Main controller. Readback words are flushed from WAIT_WORD (full word
  // after the per-word bubble) or FINISH (last, possibly partial word);
  // rd_sreg is cleared on every flush so a partial word has zero upper bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel_q      <= 1'b0;
      sreg       <= '0;
      word_bit   <= '0;
      bit_cnt    <= '0;
      rd_sreg    <= '0;
      rd_bit     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            sel_q   <= bus.chain_sel;
            bit_cnt <= '0;
            rd_bit  <= '0;
            rd_sreg <= '0;
            state   <= ST_WAIT_WORD;
          end
        end
        ST_WAIT_WORD: begin
          if (rd_bit != '0) begin
            rd_data_q  <= rd_sreg;
            rd_valid_q <= 1'b1;
            rd_bit     <= '0;
            rd_sreg    <= '0;
          end
          if (bus.data_valid) begin
            sreg     <= bus.data_in;
            word_bit <= '0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          rd_sreg[rd_bit[IDX_W-1:0]] <= scan_out_sel;
          rd_bit   <= rd_bit + WB_W'(1);
          sreg     <= sreg >> 1;
          word_bit <= word_bit + WB_W'(1);
          bit_cnt  <= bit_cnt + CNT_WIDTH'(1);
          if (last_bit) begin
            state <= ST_FINISH;
          end else if (last_of_word) begin
            state <= ST_WAIT_WORD;
          end
        end
        ST_FINISH: begin
          if (rd_bit != '0) begin
            rd_data_q  <= rd_sreg;
            rd_valid_q <= 1'b1;
            rd_bit     <= '0;
            rd_sreg    <= '0;
          end
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_config_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_config_ctrl
// Directed bench for scan_config_ctrl with behavioural models of both scan
// chains. Expected readback words are queued when a load is started (taken
// from the chain model's content before the load) and popped as the words
// observed on rd_data are compared.
// ---------------------------------------------------------------------------
module tb_scan_config_ctrl;

  localparam int DW       = 8;
  localparam int CLB_LEN  = 12;
  localparam int CONN_LEN = 20;

  logic clk = 1'b0;
  logic rst;
  logic clb_scan_in, clb_scan_en, clb_scan_out;
  logic conn_scan_in, conn_scan_en, conn_scan_out;

  scan_config_ctrl_if #(.DATA_WIDTH(DW)) bus();

  scan_config_ctrl #(
    .DATA_WIDTH(DW),
    .CLB_CHAIN_LEN(CLB_LEN),
    .CONN_CHAIN_LEN(CONN_LEN),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .clb_scan_in(clb_scan_in),
    .clb_scan_en(clb_scan_en),
    .clb_scan_out(clb_scan_out),
    .conn_scan_in(conn_scan_in),
    .conn_scan_en(conn_scan_en),
    .conn_scan_out(conn_scan_out)
  );

  always #5 clk = ~clk;

  // Chain models: shift towards bit 0, scan_out is bit 0, scan_in enters at
  // the top, so after LEN shifts bit 0 holds the first bit shifted in.
  logic [CLB_LEN-1:0]  clb_model = '0;
  logic [CONN_LEN-1:0] conn_model = '0;
  logic                clb_preload = 1'b0;
  logic [CLB_LEN-1:0]  clb_preload_val = '0;

  assign clb_scan_out  = clb_model[0];
  assign conn_scan_out = conn_model[0];

  always @(posedge clk) begin
    if (clb_preload) clb_model <= clb_preload_val;
    else if (clb_scan_en) clb_model <= {clb_scan_in, clb_model[CLB_LEN-1:1]};
    if (conn_scan_en) conn_model <= {conn_scan_in, conn_model[CONN_LEN-1:1]};
  end

  // Mid-cycle observer: counts shift cycles, done pulses, enable overlap
  // and records every readback word.
  int        clb_en_count = 0;
  int        conn_en_count = 0;
  int        done_count = 0;
  int        overlap_count = 0;
  int        rd_count = 0;
  logic [7:0] rd_obs [64];

  always @(negedge clk) begin
    if (clb_scan_en) clb_en_count <= clb_en_count + 1;
    if (conn_scan_en) conn_en_count <= conn_en_count + 1;
    if (clb_scan_en && conn_scan_en) overlap_count <= overlap_count + 1;
    if (bus.done) done_count <= done_count + 1;
    if (bus.rd_valid) begin
      rd_obs[rd_count % 64] <= bus.rd_data;
      rd_count <= rd_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete load: start, hand over each word (optionally stalling
  // data_valid, optionally pulsing a stray start), wait for done and then
  // compare the shift counts and readback words.
  task automatic applyStimulus(input logic sel, input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] w2, input int stall, input bit bad_start);
    int len;
    int nwords;
    int t;
    int clb0, conn0, done0, rd0, ovl0;
    logic [31:0] old;
    logic [7:0] words [3];
    logic [7:0] exp;
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    len    = sel ? CONN_LEN : CLB_LEN;
    nwords = (len + DW - 1) / DW;
    old    = sel ? {12'b0, conn_model} : {20'b0, clb_model};
    clb0   = clb_en_count;
    conn0  = conn_en_count;
    done0  = done_count;
    rd0    = rd_count;
    ovl0   = overlap_count;
    for (int k = 0; k < nwords; k++) exp_q.push_back(old[k*8 +: 8]);

    bus.start = 1'b1;
    bus.chain_sel = sel;
    step();
    bus.start = 1'b0;
    checkOutput("busy_after_start", bus.busy, 1);

    for (int i = 0; i < nwords; i++) begin
      t = 0;
      while (!bus.data_ready && t < 50) begin
        step();
        t++;
      end
      checkOutput("ready_wait", bus.data_ready, 1);
      for (int s = 0; s < stall; s++) begin
        step();
        checkOutput("stall_scan_en", {31'b0, clb_scan_en | conn_scan_en}, 0);
      end
      bus.data_in = words[i];
      bus.data_valid = 1'b1;
      step();
      bus.data_valid = 1'b0;
      if (bad_start && i == 0) begin
        bus.start = 1'b1;
        bus.chain_sel = ~sel;
        step();
        bus.start = 1'b0;
        bus.chain_sel = sel;
      end
    end

    t = 0;
    while (!bus.done && t < 100) begin
      step();
      t++;
    end
    checkOutput("done_seen", bus.done, 1);
    step();
    checkOutput("busy_fall", bus.busy, 0);
    checkOutput("done_one_cycle", bus.done, 0);
    step();
    step();

    checkOutput("clb_shift_cycles", clb_en_count - clb0, sel ? 0 : CLB_LEN);
    checkOutput("conn_shift_cycles", conn_en_count - conn0, sel ? CONN_LEN : 0);
    checkOutput("done_pulses", done_count - done0, 1);
    checkOutput("scan_en_overlap", overlap_count - ovl0, 0);
    checkOutput("rd_words", rd_count - rd0, nwords);
    for (int j = 0; j < nwords && exp_q.size() > 0; j++) begin
      exp = exp_q.pop_front();
      if (j < rd_count - rd0) checkOutput("rd_data", rd_obs[(rd0 + j) % 64], exp);
    end
    exp_q.delete();
  endtask

  initial begin
    int t, clb0, done0, rd0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.chain_sel = 1'b0;
    bus.data_in = '0;
    bus.data_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_ready", bus.data_ready, 0);
    checkOutput("rst_rd_valid", bus.rd_valid, 0);
    checkOutput("rst_rd_data", bus.rd_data, 0);
    checkOutput("rst_scan_en", {30'b0, clb_scan_en, conn_scan_en}, 0);
    checkOutput("rst_scan_in", {30'b0, clb_scan_in, conn_scan_in}, 0);

    $display("[TB] CLB load A5 3C");
    applyStimulus(1'b0, 8'hA5, 8'h3C, 8'h00, 0, 1'b0);
    checkOutput("clb_contents_1", clb_model, 12'hCA5);
    checkOutput("conn_untouched_1", conn_model, 20'h00000);

    $display("[TB] readback with preloaded CLB chain");
    clb_preload_val = 12'hABC;
    clb_preload = 1'b1;
    step();
    clb_preload = 1'b0;
    applyStimulus(1'b0, 8'hA5, 8'h3C, 8'h00, 0, 1'b0);
    checkOutput("clb_contents_2", clb_model, 12'hCA5);

    $display("[TB] connection chain with stalling host");
    applyStimulus(1'b1, 8'hFF, 8'h00, 8'h0F, 5, 1'b0);
    checkOutput("conn_contents", conn_model, 20'hF00FF);
    checkOutput("clb_untouched", clb_model, 12'hCA5);

    $display("[TB] stray start during CLB load");
    applyStimulus(1'b0, 8'h12, 8'h34, 8'h00, 0, 1'b1);
    checkOutput("clb_contents_3", clb_model, 12'h412);
    checkOutput("conn_untouched_2", conn_model, 20'hF00FF);

    $display("[TB] reset mid-shift");
    clb0  = clb_en_count;
    done0 = done_count;
    rd0   = rd_count;
    bus.start = 1'b1;
    bus.chain_sel = 1'b0;
    step();
    bus.start = 1'b0;
    bus.data_in = 8'h77;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    t = 0;
    while ((clb_en_count - clb0) < 4 && t < 40) begin
      step();
      t++;
    end
    checkOutput("reach_shift_5", clb_en_count - clb0, 4);
    checkOutput("in_shift_5", clb_scan_en, 1);
    rst = 1'b1;
    step();
    checkOutput("mid_rst_busy", bus.busy, 0);
    checkOutput("mid_rst_done", bus.done, 0);
    checkOutput("mid_rst_ready", bus.data_ready, 0);
    checkOutput("mid_rst_rd_valid", bus.rd_valid, 0);
    checkOutput("mid_rst_rd_data", bus.rd_data, 0);
    checkOutput("mid_rst_scan", {28'b0, clb_scan_en, conn_scan_en, clb_scan_in, conn_scan_in}, 0);
    rst = 1'b0;
    repeat (3) step();
    checkOutput("mid_rst_no_done", done_count - done0, 0);
    checkOutput("mid_rst_no_rd", rd_count - rd0, 0);
    checkOutput("mid_rst_idle", bus.busy, 0);

    $display("[TB] full load after reset");
    applyStimulus(1'b0, 8'h5A, 8'h96, 8'h00, 0, 1'b0);
    checkOutput("clb_contents_4", clb_model, 12'h65A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_config_ctrl.md
Name: scan_config_ctrl

Overview:
- Configuration loader for the tiled FPGA array. It accepts bitstream words from a host over a valid/ready interface and serialises them into one of the two array scan chains, CLB or connection, driving that chain's scan_in/scan_en.
- While shifting, it captures the chain's scan_out and returns the displaced previous configuration as readback words.
- It sits beside the array top level. Its scan outputs drive the array's clb_scan_* and conn_scan_* pins directly.

Parameters:
- DATA_WIDTH, 8: width of host config and readback words.
- CLB_CHAIN_LEN, 64: total bits in the CLB scan chain (≥1).
- CONN_CHAIN_LEN, 256: total bits in the connection scan chain (≥1).
- CNT_WIDTH, 16: width of the bit counter. Must satisfy 2^CNT_WIDTH > max(chain lengths).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- chain_sel  in  1  sampled with start; 0 = CLB chain, 1 = connection chain.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse when the selected chain is fully loaded.
- data_in  in  DATA_WIDTH  config word; bit 0 is shifted first.
- data_valid  in  1  host word valid.
- data_ready  out  1  controller can accept a word.
- rd_data  out  DATA_WIDTH  readback word; bit 0 is the first bit captured.
- rd_valid  out  1  one-cycle pulse, no backpressure.
- clb_scan_in  out  1  serial data to the CLB chain.
- clb_scan_en  out  1  CLB chain shifts on clk while high.
- clb_scan_out  in  1  CLB chain serial output.
- conn_scan_in  out  1  serial data to the connection chain.
- conn_scan_en  out  1  connection chain shifts on clk while high.
- conn_scan_out  in  1  connection chain serial output.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - state goes to IDLE.
  - busy, done, data_ready, rd_valid, both scan_en, both scan_in and rd_data are all 0.
  - Counters and shift registers are cleared.
  - Reset mid-load abandons the load immediately. The chain is left partially shifted; no done is issued.
- States are IDLE, WAIT_WORD, SHIFT, FINISH.
- IDLE:
  - data_ready=0.
  - If start=1: latch chain_sel, clear bit_cnt and the readback bit count, and go to WAIT_WORD.
  - data_valid is ignored.
- WAIT_WORD:
  - data_ready=1 and both scan_en=0.
  - On data_valid & data_ready: load shift register sreg ← data_in, clear word_bit, go to SHIFT.
  - No timeout; waits indefinitely.
- SHIFT, every cycle:
  - The selected chain's scan_en=1 and its scan_in=sreg[0]. The unselected chain's scan_en=0 and scan_in=0.
  - Capture: rd_sreg bit at index rd_bit ← the selected chain's scan_out, sampled at this edge. rd_bit increments.
  - sreg shifts right by 1; word_bit and bit_cnt increment.
  - data_ready=0.
- SHIFT exit conditions:
  - If bit_cnt+1 == selected chain length: go to FINISH. Unshifted remaining bits of the current word are discarded.
  - Else if word_bit+1 == DATA_WIDTH: go to WAIT_WORD. This inserts at least one bubble cycle with scan_en=0 per word.
- Readback:
  - When rd_bit reaches DATA_WIDTH, the next cycle presents rd_data=rd_sreg with rd_valid=1, and rd_bit resets.
  - On entry to FINISH with rd_bit>0, a final partial word is emitted with unused upper bits 0.
  - Total readback words = ceil(LEN/DATA_WIDTH).
- FINISH:
  - Lasts one cycle: done=1, both scan_en=0, then go to IDLE.
  - busy=0 from the next cycle.
- start while not in IDLE is ignored; chain_sel is not re-sampled.
- busy=1 in WAIT_WORD, SHIFT and FINISH.
- scan_en must never be high on both chains in the same cycle.
- Throughput is DATA_WIDTH shift cycles per word plus a minimum of 1 bubble. A host holding data_valid high achieves DATA_WIDTH+1 cycles per word.

Test Plan:
- Bench parameters: DATA_WIDTH=8, CLB_CHAIN_LEN=12, CONN_CHAIN_LEN=20, with a behavioural shift-register model of each chain.
- CLB load: start, chain_sel=0, words 0xA5 then 0x3C. Required response:
  - clb_scan_en is high for exactly 12 shift cycles; conn_scan_en stays 0 throughout.
  - The model holds bits A5[0..7] then 3C[0..3]; the upper nibble of 0x3C is discarded.
  - done pulses once; busy falls the cycle after.
- Readback: preload the CLB model with 12'hABC, then load as in the CLB test. Required response:
  - rd_data 0xBC with rd_valid, then 0x0A (partial word, upper bits 0).
  - Exactly 2 rd_valid pulses.
- Connection chain with a stalling host: chain_sel=1, words 0xFF, 0x00, 0x0F, with data_valid delayed 5 cycles before each. Required response:
  - scan_en is 0 during the stalls; exactly 20 shift cycles in total.
  - The model holds 8×1, 8×0, 4×1.
- Ignored start: pulse start (chain_sel=1) during a CLB load. Required response: no effect; the load completes normally on the CLB chain.
- Reset mid-shift: assert rst at shift cycle 5 of a CLB load. Required response:
  - The next cycle shows all outputs 0 and state IDLE; no done pulse.
  - A subsequent full load completes correctly.
